// File: rtl/lc3_mmio_pkg.sv
// Shared constants and FSM state type for the LC-3 memory-mapped console.
package lc3_mmio_pkg;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;

   localparam int unsigned READY_BIT = 15;
   localparam int unsigned IE_BIT    = 14;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/lc3_kb_fifo.sv
// Keyboard byte FIFO: extra pointer MSB distinguishes full from empty.
module lc3_kb_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; wraps modulo 2*DEPTH
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage array write
   always_ff @(posedge i_CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/lc3_mmio_console.sv
// LC-3 memory-mapped console: KBSR/KBDR/DSR/DDR with memory-style handshake.
// Optional build macro LC3_MMIO_INT_EN enables the interrupt-enable bits and o_Int.
module lc3_mmio_console
   import lc3_mmio_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_MIO_EN,
   input  logic        i_RW,
   input  logic [15:0] i_Addr,
   input  logic [15:0] i_Wr_Data,
   output logic        o_Sel,
   output logic [15:0] o_Rd_Data,
   output logic        o_Ready_Bit,
   input  logic        i_Kb_Valid,
   input  logic [7:0]  i_Kb_Data,
   output logic        o_Kb_Ready,
   output logic        o_Disp_Valid,
   output logic [7:0]  o_Disp_Data,
   input  logic        i_Disp_Ready,
   output logic        o_Int
);

   state_t      state;
   state_t      state_next;
   logic        acc_fire;
   logic        sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
   logic        rd_fire, wr_fire;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic [7:0]  fifo_head;
   logic [7:0]  last_kb;
   logic        kb_ie, ds_ie;
   logic [15:0] rd_mux;

   assign sel_kbsr = (i_Addr == ADDR_KBSR);
   assign sel_kbdr = (i_Addr == ADDR_KBDR);
   assign sel_dsr  = (i_Addr == ADDR_DSR);
   assign sel_ddr  = (i_Addr == ADDR_DDR);
   assign o_Sel    = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

   assign rd_fire  = acc_fire & ~i_RW;
   assign wr_fire  = acc_fire & i_RW;
   assign fifo_pop = rd_fire & sel_kbdr & ~fifo_empty;

   assign o_Kb_Ready = ~fifo_full;

   lc3_kb_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .push  (i_Kb_Valid & ~fifo_full),
      .pop   (fifo_pop),
      .din   (i_Kb_Data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // State register
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) state <= IDLE;
      else       state <= state_next;
   end

   // Next state; a DDR write waits until the previous byte is accepted
   always_comb begin
      state_next = state;
      acc_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (i_MIO_EN && o_Sel) state_next = ACCESS;
         end
         ACCESS: begin
            if (!(i_RW && sel_ddr && o_Disp_Valid && !i_Disp_Ready)) begin
               state_next = DONE;
               acc_fire   = 1'b1;
            end
         end
         DONE: begin
            if (!i_MIO_EN) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Register read mux
   always_comb begin
      rd_mux = 16'h0000;
      if (sel_kbsr) begin
         rd_mux[READY_BIT] = ~fifo_empty;
         rd_mux[IE_BIT]    = kb_ie;
      end else if (sel_kbdr) begin
         rd_mux[7:0] = fifo_empty ? last_kb : fifo_head;
      end else if (sel_dsr) begin
         rd_mux[READY_BIT] = ~o_Disp_Valid;
         rd_mux[IE_BIT]    = ds_ie;
      end
   end

   // Read data, ready bit and last keyboard byte
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_Rd_Data   <= 16'h0000;
         o_Ready_Bit <= 1'b0;
         last_kb     <= 8'h00;
      end else begin
         o_Ready_Bit <= (state_next == DONE);
         if (rd_fire)  o_Rd_Data <= rd_mux;
         if (fifo_pop) last_kb   <= fifo_head;
      end
   end

   // Display stream: a new byte may load in the same edge the old one is taken
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_Disp_Valid <= 1'b0;
         o_Disp_Data  <= 8'h00;
      end else if (wr_fire && sel_ddr) begin
         o_Disp_Valid <= 1'b1;
         o_Disp_Data  <= i_Wr_Data[7:0];
      end else if (o_Disp_Valid && i_Disp_Ready) begin
         o_Disp_Valid <= 1'b0;
      end
   end

`ifdef LC3_MMIO_INT_EN
   logic unused_wr_bits;
   assign unused_wr_bits = ^{i_Wr_Data[15], i_Wr_Data[13:8]};

   // Interrupt-enable bits
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         kb_ie <= 1'b0;
         ds_ie <= 1'b0;
      end else if (wr_fire) begin
         if (sel_kbsr) kb_ie <= i_Wr_Data[IE_BIT];
         if (sel_dsr)  ds_ie <= i_Wr_Data[IE_BIT];
      end
   end

   // Registered interrupt request
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) o_Int <= 1'b0;
      else       o_Int <= (~fifo_empty & kb_ie) | (~o_Disp_Valid & ds_ie);
   end
`else
   logic unused_wr_bits;
   assign unused_wr_bits = ^i_Wr_Data[15:8];

   assign kb_ie = 1'b0;
   assign ds_ie = 1'b0;
   assign o_Int = 1'b0;
`endif

endmodule

// File: doc/lc3_mmio_console.md
# lc3_mmio_console

Memory-mapped console device for the LC-3 CPU. Sits beside the memory array on the memory-control side of the bus. It decodes the MAR address against the device registers KBSR (xFE00), KBDR (xFE02), DSR (xFE04) and DDR (xFE06), and completes reads and writes with the same MIO_EN/R.W/ready-bit handshake that memory uses. It buffers keyboard bytes in a small FIFO and drives a valid/ready byte stream toward the display.

## Interface
- Clock is `i_CLK`; reset is `i_RST`, asynchronous and active-high.
- FIFO_DEPTH, 4: keyboard FIFO entries; power of two, ≥2.
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous active-high reset.
- i_MIO_EN  in  1  memory access request; held high until the ready bit is seen.
- i_RW  in  1  1 = write, 0 = read.
- i_Addr  in  16  MAR contents.
- i_Wr_Data  in  16  MDR contents (write data).
- o_Sel  out  1  combinational; 1 when i_Addr is one of the four device addresses. The top level uses it to mux o_Rd_Data and o_Ready_Bit over memory.
- o_Rd_Data  out  16  registered read data.
- o_Ready_Bit  out  1  access complete.
- i_Kb_Valid / i_Kb_Data[7:0] / o_Kb_Ready: keyboard byte input stream.
- o_Disp_Valid / o_Disp_Data[7:0] / i_Disp_Ready: display byte output stream.
- o_Int  out  1  interrupt request.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when i_MIO_EN & o_Sel.
- ACCESS performs the side effect exactly once. It goes to DONE the same cycle, except for a DDR write while o_Disp_Valid=1, which holds in ACCESS.
- DONE drives o_Ready_Bit=1 and stays there while i_MIO_EN=1. It returns to IDLE when i_MIO_EN=0.
- Addresses outside the four registers: FSM stays IDLE; o_Ready_Bit=0; o_Rd_Data unchanged.
- KBSR read: {fifo_not_empty, kb_ie, 14'b0}. KBSR write: only bit 14 is captured.
- KBDR read, FIFO non-empty: {8'h00, head}; pop; the byte is also saved as last_kb.
- KBDR read, FIFO empty: {8'h00, last_kb}; no pop.
- DSR read: {~o_Disp_Valid, ds_ie, 14'b0}. DSR write: only bit 14 is captured.
- DDR write: o_Disp_Data ← i_Wr_Data[7:0]; o_Disp_Valid ← 1.
- DDR read returns 16'h0000. Writes to KBDR are ignored but still complete.
- Display handshake: o_Disp_Valid stays high until a cycle with i_Disp_Ready=1, then clears the next edge. o_Disp_Data is stable while valid.
- Keyboard FIFO: push on i_Kb_Valid & o_Kb_Ready. o_Kb_Ready = ~full, derived from registered pointers. No byte is ever dropped.
- Simultaneous push and KBDR pop when not full: both take effect and the count is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. full/empty come from the MSB comparison.
- o_Int = (fifo_not_empty & kb_ie) | (~o_Disp_Valid & ds_ie), registered.

## Timing
- Reset values: FSM IDLE, FIFO empty, pointers 0, last_kb 0, kb_ie/ds_ie 0, o_Rd_Data 0, o_Ready_Bit 0, o_Disp_Valid 0, o_Disp_Data 0, o_Int 0, o_Kb_Ready 1.
- Reset mid-access aborts immediately. Any unsent display byte and all FIFO contents are lost.
- Read latency: i_MIO_EN sampled high at edge N puts the FSM in ACCESS. o_Rd_Data is loaded at edge N+1 and o_Ready_Bit is high from N+1, matching memory's one-cycle ready.
- A DDR write stalls while o_Disp_Valid=1. It completes on the edge after the display accepts the prior byte: valid clears, the new byte loads, and ready rises together.
- The pop and the status update are visible to a KBSR read issued in the immediately following access.

## Configuration
- LC3_MMIO_INT_EN defined: kb_ie/ds_ie are writable and o_Int operates as above.
- LC3_MMIO_INT_EN undefined: bit 14 of KBSR/DSR reads 0, writes to it are ignored, and o_Int is tied 0.

## Structure
- Package lc3_mmio_pkg holds:
  - constants ADDR_KBSR=16'hFE00, ADDR_KBDR=16'hFE02, ADDR_DSR=16'hFE04, ADDR_DDR=16'hFE06;
  - status bit indices READY_BIT=15, IE_BIT=14;
  - the FSM state typedef.
- One sub-module, lc3_kb_fifo: parameterised synchronous FIFO with push/pop/full/empty/head. The rest stays flat.

## Test plan
- Reset, then read KBSR: o_Rd_Data=16'h0000, o_Ready_Bit=1 one cycle after i_MIO_EN, o_Kb_Ready=1.
- Push 'A' (8'h41), then read KBSR → 16'h8000. Read KBDR → 16'h0041. Read KBSR → 16'h0000. Read KBDR again → 16'h0041 with no underflow.
- Push 5 bytes with FIFO_DEPTH=4: o_Kb_Ready drops after the 4th and the 5th is held off. Four KBDR reads return the bytes in order; the 5th is accepted once space frees.
- Write DDR 16'h0048 with i_Disp_Ready=0 for 3 cycles: o_Disp_Valid=1 and o_Disp_Data=8'h48. A second DDR write holds o_Ready_Bit=0 until i_Disp_Ready=1, then the new byte loads.
- Access to x3000 with i_MIO_EN=1: o_Sel=0, o_Ready_Bit stays 0, no state change.
- With LC3_MMIO_INT_EN: write KBSR 16'h4000, push a byte → o_Int=1 within 2 cycles. Assert i_RST mid-DDR-stall → all outputs return to reset values asynchronously.
